step_delay_timer: RTL and testbench
===================================

Name: step_delay_timer

Overview:
- Programmable delay timer that paces motor steps and PAUSE instructions for the stepper ASIP control FSM.
- Sits directly downstream of the control FSM: consumes `start_delay_counter` and `enable_delay_counter`, and returns `delay_done`.
- Delay length is `delay_value` ticks, where one tick is (`prescale_value`+1) clocks. Both operands are captured at arm time from the datapath delay/rate registers.

Parameters:
- CNT_W, 24, width of the delay tick counter and of `delay_value`.
- PRE_W, 8, width of the clock prescaler and of `prescale_value`.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start_delay_counter  input  1  arm/load request from control FSM.
- enable_delay_counter  input  1  count enable from control FSM.
- delay_value  input  CNT_W  delay length in ticks; sampled only on arm.
- prescale_value  input  PRE_W  clocks per tick minus 1; sampled only on arm.
- delay_done  output  1  registered one-cycle pulse marking delay expiry.
- busy  output  1  high while armed or counting (states ARMED, COUNTING).
- count_out  output  CNT_W  current remaining tick count, for debug and test.

Behaviour:
- Reset (reset_n=0 at a clk edge), taking priority over everything:
  - state=IDLE, count=0, pre=0.
  - delay_done=0, busy=0, count_out=0.
- States: IDLE, ARMED, COUNTING, EXPIRED.
- Arm: start=1 and enable=0 in any state.
  - count <= (delay_value==0 ? 1 : delay_value).
  - pre <= prescale_value.
  - delay_done <= 0; state <= ARMED.
  - Re-arming mid-count discards the old count.
- Count: enable=1 in ARMED or COUNTING; start is ignored while enable=1.
  - If pre!=0: pre decrements.
  - If pre==0: pre reloads with the captured prescale value and count decrements.
  - state <= COUNTING.
- Expiry: in the enabled cycle where pre==0 and count==1:
  - count <= 0, delay_done <= 1, state <= EXPIRED.
- Latency: total enabled cycles from arm to expiry is N = max(delay_value,1) * (prescale_value+1).
  - delay_done is high during the clock cycle after the Nth enabled cycle.
  - The FSM's DELAY state sees delay_done in that cycle and exits.
- delay_done is high for exactly one cycle, then returns to 0. EXPIRED holds count=0 until the next arm.
- enable=0 while COUNTING: count and pre freeze (hold). Counting resumes exactly where it stopped.
- enable=1 in IDLE or EXPIRED: no effect; delay_done stays 0 and no spurious pulse occurs.
- start=0, enable=0: hold all state.
- Captured prescale value is held in an internal register, so `prescale_value` may change freely after arm.
- Arithmetic is unsigned; no wrap-around is possible because the counter never decrements below 0.
- busy = (state==ARMED || state==COUNTING), registered with the state.
- count_out = count.

Test Plan:
- Basic delay: reset, then arm with delay_value=3, prescale_value=0, then hold enable=1 (start also 1, matching the FSM's MOVR_DELAY pattern).
  - delay_done pulses high for exactly 1 cycle, in the 4th cycle after enable rises.
  - count_out steps 3,2,1,0; busy drops with the pulse.
- Prescaled delay: arm with delay_value=2, prescale_value=3, enable continuously.
  - Expiry after 8 enabled cycles; count_out changes only every 4 clocks.
- Enable gap: arm with delay_value=4, prescale_value=0; enable for 2 cycles, drop enable for 5 cycles, re-enable.
  - count_out holds at 2 during the gap; done arrives after 2 further enabled cycles.
- Zero delay: arm with delay_value=0, prescale_value=0, enable.
  - Done pulse after 1 enabled cycle.
  - Subsequent enable-only cycles produce no further pulse.
- Re-arm mid-count: arm with delay_value=10, count down to 6, then arm with delay_value=2.
  - count_out=2; done after 2 enabled cycles.
- Reset mid-count: with count_out=5 and busy=1, assert reset_n=0 for 1 cycle, then enable=1 for 20 cycles with no arm.
  - count_out=0, busy=0, and delay_done stays 0 throughout.

Source files
------------

// File: rtl/step_delay_timer.sv
// Programmable step/PAUSE delay timer for the stepper ASIP control FSM.
// A delay of delay_value ticks is paced by a prescaler that divides the
// clock by (prescale_value+1). Both operands are captured when armed.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset, nothing armed; enable has no effect
// ARMED    | count/prescaler loaded, waiting for the first enabled cycle
// COUNTING | counting down on enabled cycles, holding when enable drops
// EXPIRED  | delay finished, count held at 0 until the next arm
module step_delay_timer #(
    parameter int CNT_W = 24,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_delay_counter,
    input  logic             enable_delay_counter,
    input  logic [CNT_W-1:0] delay_value,
    input  logic [PRE_W-1:0] prescale_value,
    output logic             delay_done,
    output logic             busy,
    output logic [CNT_W-1:0] count_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COUNTING = 2'd2,
        EXPIRED  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pre_cap_q, pre_cap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic arm;
    logic run;

    // Arm wins only when enable is low; enable only counts while a delay is live.
    assign arm = start_delay_counter && !enable_delay_counter;
    assign run = enable_delay_counter && (state_q == ARMED || state_q == COUNTING);

    // Next-state, count/prescaler update and done-pulse generation.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pre_d     = pre_q;
        pre_cap_d = pre_cap_q;
        done_d    = 1'b0;

        if (arm) begin
            // A zero-length request still takes one tick so the FSM sees a pulse.
            count_d   = (delay_value == '0) ? CNT_W'(1) : delay_value;
            pre_d     = prescale_value;
            pre_cap_d = prescale_value;
            state_d   = ARMED;
        end else if (run) begin
            if (pre_q != '0) begin
                pre_d   = pre_q - PRE_W'(1);
                state_d = COUNTING;
            end else if (count_q <= CNT_W'(1)) begin
                pre_d   = pre_cap_q;
                count_d = '0;
                done_d  = 1'b1;
                state_d = EXPIRED;
            end else begin
                pre_d   = pre_cap_q;
                count_d = count_q - CNT_W'(1);
                state_d = COUNTING;
            end
        end

        busy_d = (state_d == ARMED) || (state_d == COUNTING);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pre_q     <= '0;
            pre_cap_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            pre_cap_q <= pre_cap_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign delay_done = done_q;
    assign busy       = busy_q;
    assign count_out  = count_q;

endmodule

// File: tb/tb_step_delay_timer.sv
// Directed bench for step_delay_timer: arm/count/hold/re-arm/reset scenarios.
module tb_step_delay_timer;

    localparam int CNT_W = 24;
    localparam int PRE_W = 8;

    logic             clk;
    logic             reset_n;
    logic             start_delay_counter;
    logic             enable_delay_counter;
    logic [CNT_W-1:0] delay_value;
    logic [PRE_W-1:0] prescale_value;
    logic             delay_done;
    logic             busy;
    logic [CNT_W-1:0] count_out;

    int n_checks;
    int n_fail;

    step_delay_timer #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .start_delay_counter  (start_delay_counter),
        .enable_delay_counter (enable_delay_counter),
        .delay_value          (delay_value),
        .prescale_value       (prescale_value),
        .delay_done           (delay_done),
        .busy                 (busy),
        .count_out            (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input bit dn, input bit bz);
        check({tag, " count"}, 32'(count_out), 32'(cnt));
        check({tag, " done"},  32'(delay_done), 32'(dn));
        check({tag, " busy"},  32'(busy), 32'(bz));
    endtask

    task automatic arm(input int dv, input int pv);
        start_delay_counter  = 1'b1;
        enable_delay_counter = 1'b0;
        delay_value          = CNT_W'(dv);
        prescale_value       = PRE_W'(pv);
        tick();
    endtask

    initial begin
        n_checks             = 0;
        n_fail               = 0;
        reset_n              = 1'b0;
        start_delay_counter  = 1'b0;
        enable_delay_counter = 1'b0;
        delay_value          = '0;
        prescale_value       = '0;
        tick();
        tick();
        check_all("reset", 0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Basic delay: 3 ticks, no prescale, start held with enable.
        arm(3, 0);
        check_all("basic armed", 3, 1'b0, 1'b1);
        enable_delay_counter = 1'b1;
        tick(); check_all("basic c1", 2, 1'b0, 1'b1);
        tick(); check_all("basic c2", 1, 1'b0, 1'b1);
        tick(); check_all("basic c3", 0, 1'b1, 1'b0);
        tick(); check_all("basic after", 0, 1'b0, 1'b0);
        start_delay_counter  = 1'b0;
        enable_delay_counter = 1'b0;
        tick();

        // Prescaled delay: 2 ticks x 4 clocks; prescale input changes after arm.
        arm(2, 3);
        check_all("pre armed", 2, 1'b0, 1'b1);
        start_delay_counter  = 1'b0;
        enable_delay_counter = 1'b1;
        prescale_value       = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_all("pre cycle", (i < 4) ? 2 : ((i < 8) ? 1 : 0), i == 8, i != 8);
        end
        tick(); check_all("pre after", 0, 1'b0, 1'b0);

        // Enable gap: count freezes while enable is low.
        arm(4, 0);
        start_delay_counter  = 1'b0;
        enable_delay_counter = 1'b1;
        tick(); check_all("gap c1", 3, 1'b0, 1'b1);
        tick(); check_all("gap c2", 2, 1'b0, 1'b1);
        enable_delay_counter = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("gap hold", 2, 1'b0, 1'b1);
        end
        enable_delay_counter = 1'b1;
        tick(); check_all("gap c3", 1, 1'b0, 1'b1);
        tick(); check_all("gap c4", 0, 1'b1, 1'b0);

        // Zero delay behaves as one tick; further enables in EXPIRED do nothing.
        arm(0, 0);
        check_all("zero armed", 1, 1'b0, 1'b1);
        start_delay_counter  = 1'b0;
        enable_delay_counter = 1'b1;
        tick(); check_all("zero done", 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("zero quiet", 0, 1'b0, 1'b0);
        end

        // Re-arm mid-count discards the old count.
        arm(10, 0);
        start_delay_counter  = 1'b0;
        enable_delay_counter = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_all("rearm at6", 6, 1'b0, 1'b1);
        arm(2, 0);
        check_all("rearm load", 2, 1'b0, 1'b1);
        start_delay_counter  = 1'b0;
        enable_delay_counter = 1'b1;
        tick(); check_all("rearm c1", 1, 1'b0, 1'b1);
        tick(); check_all("rearm c2", 0, 1'b1, 1'b0);

        // Reset mid-count, then enable alone must not restart anything.
        arm(8, 0);
        start_delay_counter  = 1'b0;
        enable_delay_counter = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_all("rst pre", 5, 1'b0, 1'b1);
        reset_n              = 1'b0;
        enable_delay_counter = 1'b0;
        tick(); check_all("rst apply", 0, 1'b0, 1'b0);
        reset_n              = 1'b1;
        enable_delay_counter = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("rst idle en", 0, 1'b0, 1'b0);
        end
        enable_delay_counter = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
